dac_spi_ctrl: RTL



---
 rtl/dac_spi_ctrl.sv | 121 ++++++++++++
 1 files changed

// File: rtl/dac_spi_ctrl.sv
// Serial DAC controller: pops write instructions from the queue and shifts each one
// out as a 24-bit {cmd, addr, data} frame on a 3-wire SPI port (SCLK, DIN, SYNC_N).
module dac_spi_ctrl #(
  parameter int                          W_DATA     = 16,
  parameter int                          W_CHS      = 3,
  parameter int                          W_CMD      = 4,
  parameter logic [W_CMD-1:0]            CMD_WRITE  = 4'h3,
  parameter int                          SCLK_DIV   = 2,
  parameter int                          T_GAP      = 4,
  parameter bit                          INIT_EN    = 1'b1,
  parameter logic [W_CMD+4+W_DATA-1:0]   INIT_FRAME = 24'h800001
) (
  input  logic              clk_in,
  input  logic              reset_in,
  input  logic [W_DATA-1:0] data_in,
  input  logic [W_CHS-1:0]  chan_in,
  input  logic              data_valid_in,
  output logic              rd_ack_out,
  output logic              dac_sclk_out,
  output logic              dac_din_out,
  output logic              dac_nsync_out,
  output logic              busy_out,
  output logic              done_out,
  output logic              init_done_out
);

  localparam int W_FRAME = W_CMD + 4 + W_DATA;
  localparam int W_DIV   = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam int W_BIT   = $clog2(W_FRAME);
  localparam int W_GAP   = (T_GAP > 1) ? $clog2(T_GAP) : 1;

  localparam logic [W_DIV-1:0] DIV_LAST = W_DIV'(SCLK_DIV - 1);
  localparam logic [W_BIT-1:0] BIT_LAST = W_BIT'(W_FRAME - 1);
  localparam logic [W_GAP-1:0] GAP_LAST = W_GAP'(T_GAP - 1);

  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_SHIFT, ST_GAP} state_t;

  state_t             state;
  // The bit currently on the pin lives in dac_din_out; shift_reg holds the rest.
  logic [W_FRAME-2:0] shift_reg;
  logic [W_DIV-1:0]   div_cnt;
  logic [W_BIT-1:0]   bit_cnt;
  logic [W_GAP-1:0]   gap_cnt;
  logic               is_init;

  assign busy_out = (state != ST_IDLE);

  // NOTE: all state and outputs are updated with non-blocking assignments so every
  // register in this block sees the pre-edge values of the others.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      if (INIT_EN) state <= ST_INIT;
      else         state <= ST_IDLE;
      shift_reg     <= '0;
      div_cnt       <= '0;
      bit_cnt       <= '0;
      gap_cnt       <= '0;
      is_init       <= 1'b0;
      rd_ack_out    <= 1'b0;
      dac_sclk_out  <= 1'b0;
      dac_din_out   <= 1'b0;
      dac_nsync_out <= 1'b1;
      done_out      <= 1'b0;
      init_done_out <= !INIT_EN;
    end else begin
      rd_ack_out <= 1'b0;
      done_out   <= 1'b0;
      unique case (state)
        ST_INIT: begin
          {dac_din_out, shift_reg} <= INIT_FRAME;
          is_init       <= 1'b1;
          dac_nsync_out <= 1'b0;
          div_cnt       <= '0;
          bit_cnt       <= '0;
          state         <= ST_SHIFT;
        end
        ST_IDLE: begin
          if (data_valid_in) begin
            {dac_din_out, shift_reg} <= {CMD_WRITE, 4'(chan_in), data_in};
            is_init       <= 1'b0;
            rd_ack_out    <= 1'b1;
            dac_nsync_out <= 1'b0;
            div_cnt       <= '0;
            bit_cnt       <= '0;
            state         <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            if (!dac_sclk_out) begin
              dac_sclk_out <= 1'b1;
            end else begin
              dac_sclk_out <= 1'b0;
              if (bit_cnt == BIT_LAST) begin
                // Falling edge after the last bit closes the frame.
                dac_nsync_out <= 1'b1;
                dac_din_out   <= 1'b0;
                gap_cnt       <= '0;
                state         <= ST_GAP;
                if (is_init) init_done_out <= 1'b1;
                else         done_out      <= 1'b1;
              end else begin
                {dac_din_out, shift_reg} <= {shift_reg, 1'b0};
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        ST_GAP: begin
          if (gap_cnt == GAP_LAST) state   <= ST_IDLE;
          else                     gap_cnt <= gap_cnt + 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
